csa_mult_sequencer: RTL and testbench
=====================================

Name: csa_mult_sequencer

Overview:
- Iterative unsigned multiplier controller that time-shares one 3:2 carry-save compressor row across all partial products.
- The row is built from the team's full-adder cells. It replaces a full Wallace tree where area matters.
- Accepts one operand pair, folds one partial product per cycle into a redundant (sum, carry) accumulator, then resolves it with a single carry-propagate add.
- Sits between the operand-issue logic and the result consumer; valid/ready on both sides.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product available.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  a*b, unsigned.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values: in_ready=1, out_valid=0, product=0, busy=0; state=IDLE; accumulators, operand registers and counter cleared.
- Reset mid-operation: the in-flight operation is discarded with no out_valid pulse. The block is in IDLE on the cycle after rst deasserts.
- States:
  - IDLE: in_ready=1. in_valid&in_ready -> latch a into mcand_q (zero-extended to 2*WIDTH) and b into mplier_q; clear sum_q, carry_q and cnt; go to REDUCE.
  - REDUCE: pp = mplier_q[0] ? mcand_q : 0. csa_row(sum_q, carry_q, pp) produces s and c; sum_q<=s, carry_q<=c<<1 (truncated to 2*WIDTH). Then mcand_q<<=1, mplier_q>>=1, cnt++. When cnt==WIDTH-1 go to RESOLVE.
  - RESOLVE: product<=sum_q+carry_q, truncated to 2*WIDTH; out_valid<=1; go to DONE.
  - DONE: hold product and out_valid stable. out_valid&out_ready -> out_valid<=0, go to IDLE.
- in_ready=0 in REDUCE, RESOLVE and DONE. in_valid is ignored there and operands are not sampled.
- Latency, base build: the accept edge is cycle 0, the REDUCE edges are cycles 1..WIDTH, the RESOLVE edge is cycle WIDTH+1, and out_valid is high after edge WIDTH+1. Earliest next accept is the edge after the out handshake, so throughput is at most one result per WIDTH+3 cycles.
- No overflow is possible: the result is exact modulo 2^(2*WIDTH) and equals the full product.
- a=0 or b=0 takes the same latency (except under the optional feature) and gives product=0.
- out_ready held low: DONE persists indefinitely and product does not change.

Optional Feature:
- Macro: CSA_MULT_EARLY_TERM_EN.
- Defined: in REDUCE, if the next-cycle mplier_q (after shift) is all zero, go to RESOLVE immediately.
  - If b==0 at accept, go from IDLE straight to RESOLVE.
  - Latency becomes (index of MSB set in b)+2 cycles, or 1 cycle for b==0.
- Not defined: fixed WIDTH+1 cycle latency as above; no zero-detect logic is instantiated.

Decomposition:
- Shared package csa_mult_pkg holds:
  - state enum type csa_state_t (IDLE, REDUCE, RESOLVE, DONE);
  - localparam DEF_WIDTH=32.
- One sub-module: csa_row, a WIDTH-parameterised array of full-adder cells. Inputs x, y, z; outputs s and c, each of the array width. The sequencer instantiates it at width 2*WIDTH.
- The final add is inline; no second sub-module.

Test Plan:
- a=3, b=5, out_ready=1 -> product=15; out_valid rises exactly WIDTH+1 cycles after accept (base build).
- a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001; same latency.
- in_valid held high with new operands throughout an operation -> in_ready=0 until after the out handshake; the second pair is accepted on the first IDLE cycle and its result is correct.
- out_ready=0 for 10 cycles after out_valid -> product and out_valid held stable; one-cycle out_ready pulse -> out_valid=0 next cycle, in_ready=1.
- rst asserted for one cycle in the middle of REDUCE -> next cycle state=IDLE, out_valid=0, busy=0, product=0; a following a=7, b=9 gives 63.
- With CSA_MULT_EARLY_TERM_EN: b=1, a=0x1234 -> product=0x1234 after 2 cycles; b=0 -> product=0 after 1 cycle.

Source files
------------

// File: rtl/csa_mult_pkg.sv
// Shared types and defaults for the carry-save iterative multiplier.
package csa_mult_pkg;
   localparam int DEF_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REDUCE  = 2'd1,
      RESOLVE = 2'd2,
      DONE    = 2'd3
   } csa_state_t;
endpackage

// File: rtl/csa_row.sv
// One row of independent full-adder cells: x + y + z == s + 2*c, bitwise.
module csa_row #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] z,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] c
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign s[i] = x[i] ^ y[i] ^ z[i];
      assign c[i] = (x[i] & y[i]) | (x[i] & z[i]) | (y[i] & z[i]);
   end
endmodule

// File: rtl/csa_mult_sequencer.sv
// Iterative unsigned multiplier: one partial product per cycle through a shared
// carry-save row, then one carry-propagate add. Optional: CSA_MULT_EARLY_TERM_EN.
module csa_mult_sequencer
   import csa_mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);
   localparam int PW = 2 * WIDTH;

   csa_state_t       state_q, state_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [PW-1:0]    sum_q, sum_d;
   logic [PW-1:0]    carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    product_q, product_d;
   logic             out_valid_q, out_valid_d;

   logic [PW-1:0]    pp;
   logic [PW-1:0]    csa_s;
   logic [PW-1:0]    csa_c;
   logic [WIDTH-1:0] mplier_shift;
   logic             last_pp;

   assign pp           = mplier_q[0] ? mcand_q : '0;
   assign mplier_shift = mplier_q >> 1;

   csa_row #(.WIDTH(PW)) u_row (
      .x (sum_q),
      .y (carry_q),
      .z (pp),
      .s (csa_s),
      .c (csa_c)
   );

`ifdef CSA_MULT_EARLY_TERM_EN
   // Stop once no set multiplier bits remain to be folded in.
   assign last_pp = (mplier_shift == '0) || (cnt_q == CNT_W'(WIDTH - 1));
`else
   assign last_pp = (cnt_q == CNT_W'(WIDTH - 1));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mcand_q     <= '0;
         mplier_q    <= '0;
         sum_q       <= '0;
         carry_q     <= '0;
         cnt_q       <= '0;
         product_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         cnt_q       <= cnt_d;
         product_q   <= product_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      sum_d       = sum_q;
      carry_d     = carry_q;
      cnt_d       = cnt_q;
      product_d   = product_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               mcand_d  = {{WIDTH{1'b0}}, a};
               mplier_d = b;
               sum_d    = '0;
               carry_d  = '0;
               cnt_d    = '0;
               state_d  = REDUCE;
`ifdef CSA_MULT_EARLY_TERM_EN
               if (b == '0) state_d = RESOLVE;
`endif
            end
         end
         REDUCE: begin
            // Carries carry weight 2; the bit shifted out is beyond the product width.
            sum_d    = csa_s;
            carry_d  = csa_c << 1;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_shift;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_pp) state_d = RESOLVE;
         end
         RESOLVE: begin
            product_d   = sum_q + carry_q;
            out_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign product   = product_q;
endmodule

// File: tb/tb_csa_mult_sequencer.sv
// Directed self-checking bench for csa_mult_sequencer (honours CSA_MULT_EARLY_TERM_EN).
module tb_csa_mult_sequencer;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           out_ready = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic           in_ready;
   logic           out_valid;
   logic           busy;
   logic [2*W-1:0] product;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   csa_mult_sequencer #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   // Cycles from the accept edge until out_valid is observed.
   function automatic int exp_lat(input logic [W-1:0] bv);
      int m;
      m = -1;
      for (int i = 0; i < W; i++) if (bv[i]) m = i;
`ifdef CSA_MULT_EARLY_TERM_EN
      return (m < 0) ? 1 : m + 2;
`else
      return (m < -1) ? 0 : W + 1;
`endif
   endfunction

   task automatic wait_out(output int cyc);
      int c;
      c = 0;
      while (out_valid !== 1'b1 && c < 300) begin
         @(posedge clk); #1;
         c++;
      end
      cyc = (out_valid === 1'b1) ? c : -1;
   endtask

   task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
      int g;
      g = 0;
      while (in_ready !== 1'b1 && g < 300) begin
         @(posedge clk); #1;
         g++;
      end
      n_chk++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL start_timeout: in_ready=%b required 1", in_ready);
      end
      in_valid = 1'b1; a = av; b = bv;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
      n_chk++; if (product !== 64'd0) begin n_fail++; $display("FAIL reset_product: got %h need 0", product); end
   endtask

   task automatic test_small();
      int cyc;
      out_ready = 1'b1;
      start_op(32'd3, 32'd5);
      n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL small_busy: got %b need 1", busy); end
      wait_out(cyc);
      n_chk++; if (product !== 64'd15) begin n_fail++; $display("FAIL small_product: got %h need 15", product); end
      n_chk++; if (cyc !== exp_lat(32'd5)) begin n_fail++; $display("FAIL small_latency: got %0d need %0d", cyc, exp_lat(32'd5)); end
      @(posedge clk); #1;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL small_release: out_valid=%b need 0", out_valid); end
   endtask

   task automatic test_max();
      int cyc;
      out_ready = 1'b1;
      start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_out(cyc);
      n_chk++; if (product !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL max_product: got %h need fffffffe00000001", product); end
      n_chk++; if (cyc !== W + 1) begin n_fail++; $display("FAIL max_latency: got %0d need %0d", cyc, W + 1); end
      @(posedge clk); #1;
   endtask

   task automatic test_zero();
      int cyc;
      logic [W-1:0] av [2];
      logic [W-1:0] bv [2];
      av[0] = 32'd0;      bv[0] = 32'h0000_FFFF;
      av[1] = 32'h1234;   bv[1] = 32'd0;
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         start_op(av[k], bv[k]);
         wait_out(cyc);
         n_chk++; if (product !== 64'd0) begin n_fail++; $display("FAIL zero_product[%0d]: got %h need 0", k, product); end
         n_chk++; if (cyc !== exp_lat(bv[k])) begin n_fail++; $display("FAIL zero_latency[%0d]: got %0d need %0d", k, cyc, exp_lat(bv[k])); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall();
      int cyc;
      out_ready = 1'b0;
      start_op(32'h0001_0000, 32'h0003_0000);
      wait_out(cyc);
      n_chk++; if (product !== 64'h0000_0003_0000_0000) begin n_fail++; $display("FAIL stall_product: got %h need 300000000", product); end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_chk++;
         if (out_valid !== 1'b1 || product !== 64'h0000_0003_0000_0000) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: out_valid=%b product=%h need 1/300000000", i, out_valid, product);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_valid: got %b need 0", out_valid); end
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b need 1", in_ready); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      int bad_ready;
      out_ready = 1'b1;
      in_valid = 1'b1; a = 32'd100; b = 32'd200;
      @(posedge clk); #1;
      a = 32'h8000_0000; b = 32'd2;
      bad_ready = 0; cyc = 0;
      while (out_valid !== 1'b1 && cyc < 300) begin
         if (in_ready !== 1'b0) bad_ready++;
         @(posedge clk); #1;
         cyc++;
      end
      n_chk++; if (bad_ready != 0) begin n_fail++; $display("FAIL b2b_ready_low: in_ready high %0d cycles need 0", bad_ready); end
      n_chk++; if (product !== 64'd20000) begin n_fail++; $display("FAIL b2b_first: got %h need 4e20", product); end
      @(posedge clk); #1;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: in_ready=%b need 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: in_ready=%b need 0", in_ready); end
      wait_out(cyc);
      n_chk++; if (product !== 64'h0000_0001_0000_0000) begin n_fail++; $display("FAIL b2b_second: got %h need 100000000", product); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int cyc;
      int spur;
      out_ready = 1'b1;
      start_op(32'h55, 32'h66);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b need 0", busy); end
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b need 1", in_ready); end
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b need 0", out_valid); end
      n_chk++; if (product !== 64'd0) begin n_fail++; $display("FAIL mid_product: got %h need 0", product); end
      spur = 0;
      for (int i = 0; i < W + 4; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) spur++;
      end
      n_chk++; if (spur != 0) begin n_fail++; $display("FAIL mid_no_pulse: out_valid high %0d cycles need 0", spur); end
      start_op(32'd7, 32'd9);
      wait_out(cyc);
      n_chk++; if (product !== 64'd63) begin n_fail++; $display("FAIL mid_after: got %h need 3f", product); end
      @(posedge clk); #1;
   endtask

`ifdef CSA_MULT_EARLY_TERM_EN
   task automatic test_early_term();
      int cyc;
      out_ready = 1'b1;
      start_op(32'h1234, 32'd1);
      wait_out(cyc);
      n_chk++; if (product !== 64'h1234) begin n_fail++; $display("FAIL early_b1_product: got %h need 1234", product); end
      n_chk++; if (cyc !== 2) begin n_fail++; $display("FAIL early_b1_latency: got %0d need 2", cyc); end
      @(posedge clk); #1;
      start_op(32'h1234, 32'd0);
      wait_out(cyc);
      n_chk++; if (product !== 64'd0) begin n_fail++; $display("FAIL early_b0_product: got %h need 0", product); end
      n_chk++; if (cyc !== 1) begin n_fail++; $display("FAIL early_b0_latency: got %0d need 1", cyc); end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      test_reset();
      test_small();
      test_max();
      test_zero();
      test_stall();
      test_back_to_back();
      test_reset_mid();
`ifdef CSA_MULT_EARLY_TERM_EN
      test_early_term();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
